// File: rtl/gpu_pkg.sv
// Shared GPU definitions: GP0 opcode constants, packet buffer sizing and reader state encoding.
package gpu_pkg;

  localparam int unsigned MAX_WORDS = 12;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LEN_W     = 4;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_CLR_CACHE = 8'h01;
  localparam logic [7:0] OP_FILL      = 8'h02;
  localparam logic [7:0] OP_POLY_BASE = 8'h20;
  localparam logic [7:0] OP_LINE_BASE = 8'h40;
  localparam logic [7:0] OP_RECT_BASE = 8'h60;
  localparam logic [7:0] OP_ENV_LO    = 8'hE1;
  localparam logic [7:0] OP_ENV_HI    = 8'hE6;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} rd_state_t;

  typedef logic [MAX_WORDS-1:0][WORD_W-1:0] pkt_words_t;

endpackage

// File: rtl/gp0_len_decode.sv
// GP0 command byte to packet word count; flags opcodes the reader does not support.
module gp0_len_decode (
  input  logic [7:0] op,
  output logic [3:0] len,
  output logic       unknown
);
  import gpu_pkg::*;

  logic [LEN_W-1:0] nv;

  always_comb begin
    len     = LEN_W'(1);
    unknown = 1'b0;
    nv      = LEN_W'(3) + LEN_W'(op[3]);
    if (op == OP_NOP || op == OP_CLR_CACHE || (op >= OP_ENV_LO && op <= OP_ENV_HI)) begin
      len = LEN_W'(1);
    end else if (op == OP_FILL) begin
      len = LEN_W'(3);
    end else if (op[7:5] == OP_POLY_BASE[7:5]) begin
      // header + vertices * (1 + texcoord) + extra colours for gouraud
      len = LEN_W'(1) + nv * (LEN_W'(1) + LEN_W'(op[2]))
          + (op[4] ? (nv - LEN_W'(1)) : LEN_W'(0));
    end else if (op[7:5] == OP_LINE_BASE[7:5]) begin
      len = LEN_W'(3) + LEN_W'(op[4]);
    end else if (op[7:5] == OP_RECT_BASE[7:5]) begin
      len = LEN_W'(2) + LEN_W'(op[2]) + LEN_W'(op[4:3] == 2'b00);
    end else begin
      unknown = 1'b1;
    end
  end

endmodule

// File: rtl/gp0_cmd_reader.sv
// GP0 FIFO consumer: assembles whole command packets and hands them to primitive setup.
// Optional GP0_CMD_READER_TIMEOUT_EN aborts a packet starved for TIMEOUT cycles (timeout_err).
module gp0_cmd_reader #(
  parameter int unsigned MAX_WORDS = gpu_pkg::MAX_WORDS
`ifdef GP0_CMD_READER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                fifo_empty,
  input  logic [31:0]         fifo_data,
  output logic                fifo_re,
  output logic                pkt_valid,
  input  logic                pkt_ready,
  output logic [7:0]          pkt_op,
  output logic [3:0]          pkt_len,
  output gpu_pkg::pkt_words_t pkt_data,
  output logic                unk_op,
`ifdef GP0_CMD_READER_TIMEOUT_EN
  output logic                timeout_err,
`endif
  output logic                busy
);
  import gpu_pkg::*;

  rd_state_t        state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] dec_len;
  logic             dec_unk;
  logic             stall_hit;

  gp0_len_decode u_len_decode (
    .op      (fifo_data[31:24]),
    .len     (dec_len),
    .unknown (dec_unk)
  );

  assign fifo_re   = (state == IDLE || state == FETCH) && !fifo_empty && !flush;
  assign pkt_valid = (state == HOLD);
  assign busy      = (state != IDLE);

`ifdef GP0_CMD_READER_TIMEOUT_EN
  logic [7:0] stall_cnt;

  assign stall_hit = (state == FETCH) && fifo_empty && !flush
                   && (stall_cnt == 8'(TIMEOUT - 1));

  // Counts consecutive empty FETCH cycles; any pop or exit from FETCH restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= stall_hit;
      if (state != FETCH || fifo_re || stall_hit) begin
        stall_cnt <= 8'd0;
      end else if (fifo_empty) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fifo_re) state_nxt = (dec_len == LEN_W'(1)) ? HOLD : FETCH;
      end
      FETCH: begin
        if (flush || stall_hit)                           state_nxt = IDLE;
        else if (fifo_re && (cnt + LEN_W'(1) == pkt_len)) state_nxt = HOLD;
      end
      HOLD: begin
        if (flush || pkt_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word0 pop clears the buffer so words past the packet length read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      pkt_op   <= 8'd0;
      pkt_len  <= '0;
      pkt_data <= '0;
      unk_op   <= 1'b0;
    end else begin
      unk_op <= 1'b0;
      if (fifo_re) begin
        if (state == IDLE) begin
          pkt_data <= pkt_words_t'(fifo_data);
          pkt_op   <= fifo_data[31:24];
          pkt_len  <= dec_len;
          cnt      <= LEN_W'(1);
          unk_op   <= dec_unk;
        end else begin
          pkt_data[cnt] <= fifo_data;
          cnt           <= cnt + LEN_W'(1);
        end
      end
    end
  end

  a_len_range: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE && fifo_re) |-> (dec_len != '0 && 32'(dec_len) <= MAX_WORDS));

endmodule
